serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that feeds the team's single-bit full_adder cell and consumes its outputs. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It presents them to the full_adder one bit per clock, LSB first, with the carry held in a register between bits. It then returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. This is the area-minimal alternative to the ripple-carry array: one full_adder instead of WIDTH of them.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..64.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
i_clk  input  1  rising-edge clock
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  operands on i_a/i_b/i_carry valid
o_ready  output  1  block can accept operands (IDLE only)
i_a  input  WIDTH  operand A
i_b  input  WIDTH  operand B
i_carry  input  1  carry-in
o_valid  output  1  result valid; held until consumed
i_ready  input  1  downstream accepts result
o_sum  output  WIDTH  sum, registered
o_carry  output  1  carry-out, registered

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; operand shift regs, sum shift reg, carry reg, counter, o_sum, o_carry all 0; o_valid=0; o_ready=1. Release is synchronous to i_clk via the normal flop path.
- States:
  - IDLE: o_ready=1, o_valid=0. On i_valid&&o_ready at an edge:
    - load A<=i_a, B<=i_b, carry_reg<=i_carry, cnt<=0;
    - go to SHIFT.
  - SHIFT: o_ready=0. Each cycle the full_adder is driven with (A[0], B[0], carry_reg). At the edge:
    - sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
    - carry_reg <= fa_carry;
    - A, B shift right with 0 fill;
    - cnt <= cnt+1.
    - When cnt==WIDTH-1 at the edge, also load o_sum <= {fa_sum, sum_sr[WIDTH-1:1]} and o_carry <= fa_carry, then go to DONE.
  - DONE: o_valid=1, o_ready=0. o_sum/o_carry are stable. On i_ready at an edge, go to IDLE; o_sum/o_carry keep their last value.
- Latency: exactly WIDTH SHIFT cycles. o_valid rises WIDTH edges after the accept edge.
- Throughput: at best one operation per WIDTH+2 cycles (accept, WIDTH shifts, one DONE cycle with i_ready=1).
- Inputs i_a/i_b/i_carry are sampled only at the accept edge; later changes are ignored. i_valid is ignored outside IDLE.
- i_ready is ignored outside DONE. If i_ready is held high in DONE, the result is consumed in the first DONE cycle.
- Arithmetic is modulo 2^WIDTH; the overflow carry appears on o_carry. No signed interpretation.
- WIDTH=1: a single SHIFT cycle, after which cnt==0==WIDTH-1 immediately moves to DONE.
- Reset mid-operation (SHIFT or DONE): the operation is discarded, o_valid drops asynchronously, and the block returns to IDLE. There is no partial result.
- o_ready and o_valid are decoded from registered state only; there are no combinational paths from i_valid or i_ready.

Decomposition:
- Shared package serial_adder_pkg holds:
  - 2-bit state encoding constants S_IDLE=0, S_SHIFT=1, S_DONE=2 (3 is illegal and recovers to IDLE);
  - the counter-width function used for CNT_W.
- One sub-module: the existing full_adder, instantiated once for the per-bit sum and carry.
- All sequencing, shift registers and the output register live in serial_adder_ctrl.

Test Plan:
1. WIDTH=8. Accept a=0x5A, b=0x3C, carry=0 -> o_valid rises exactly 8 edges after accept; o_sum=0x96, o_carry=0.
2. a=0xFF, b=0x01, carry=0 -> o_sum=0x00, o_carry=1. Then a=0xFF, b=0xFF, carry=1 -> o_sum=0xFF, o_carry=1.
3. Backpressure: hold i_ready=0 for 5 cycles in DONE while pulsing i_valid with new operands -> o_valid stays 1, o_sum/o_carry stay unchanged, o_ready stays 0, and the new operands are not accepted. With i_ready=1, the block goes to IDLE on the next edge.
4. Change i_a/i_b during SHIFT -> result still equals the sum of the operands captured at accept.
5. Assert i_rst_n=0 at the 3rd SHIFT cycle -> o_valid=0, o_ready=1 immediately, outputs 0. The next operation 0x12+0x34+1 gives 0x47, carry 0.
6. WIDTH=1 build: a=1, b=1, carry=1 -> o_valid one edge after accept, o_sum=1, o_carry=1. Also run 1000 random vectors for WIDTH=8 and WIDTH=13 against a reference model.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_t   : 2-bit controller state encoding (IDLE/SHIFT/DONE; 3 unused)
//   - cnt_width : width of a counter that can hold the values 0..width
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit full adder cell.
// Ports:
//   i_a, i_b   : addend bits
//   i_carry    : carry-in
//   o_sum      : sum bit
//   o_carry    : carry-out
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_carry;
  assign o_carry = (i_a & i_b) | (i_carry & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: accepts two WIDTH-bit operands plus carry-in over a
// valid/ready handshake, adds them LSB first through one full_adder (one bit
// per clock, carry held in a register), and returns the WIDTH-bit sum and the
// carry-out over a second valid/ready handshake.
// Ports:
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_valid / o_ready    : operand handshake (o_ready only in IDLE)
//   i_a, i_b, i_carry    : operands, sampled only at the accept edge
//   o_valid / i_ready    : result handshake (o_valid held until consumed)
//   o_sum, o_carry       : registered result, held after consumption
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;

  logic             w_fa_sum;
  logic             w_fa_carry;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_next;

  full_adder u_full_adder (
    .i_a     (r_a[0]),
    .i_b     (r_b[0]),
    .i_carry (r_carry),
    .o_sum   (w_fa_sum),
    .o_carry (w_fa_carry)
  );

  // Handshake outputs come from the state register only: no input-to-output
  // combinational path.
  assign o_ready  = (r_state == S_IDLE);
  assign o_valid  = (r_state == S_DONE);
  assign w_accept = i_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // New sum bit enters at the MSB; after WIDTH shifts the first (LSB) bit has
  // reached bit 0. The shift-then-truncate form also covers WIDTH=1.
  assign w_sum_next = WIDTH'({w_fa_sum, r_sum_sr} >> 1);

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_valid) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  if (i_ready) w_state_nxt = S_IDLE;
      default:              w_state_nxt = S_IDLE;  // encoding 3 recovers
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sum_sr <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_carry <= i_carry;
      r_cnt   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_sum_sr <= w_sum_next;
      r_carry  <= w_fa_carry;
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_sum_next;
        r_cout <= w_fa_carry;
      end
    end
  end

  assign o_sum   = r_sum;
  assign o_carry = r_cout;

endmodule
